// File: rtl/tft_bus_arbiter_if.sv
// Bus bundle between the TFT requesters / byte transmitter and tft_bus_arbiter.
// The slave modport is the arbiter's view; master is the requester/transmitter side.
interface tft_bus_arbiter_if #(
   parameter int NUM_REQ = 3
);
   logic [NUM_REQ-1:0]   req;
   logic [NUM_REQ-1:0]   req_tx;
   logic [NUM_REQ-1:0]   req_dc;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_busy;
   logic [NUM_REQ-1:0]   gnt;
   logic                 err_drop;
   logic                 tft_busy;
   logic                 tft_dc;
   logic [7:0]           tft_data;
   logic                 tft_transmit;

   modport slave (
      input  req, req_tx, req_dc, req_data, tft_busy,
      output req_busy, gnt, err_drop, tft_dc, tft_data, tft_transmit
   );

   modport master (
      output req, req_tx, req_dc, req_data, tft_busy,
      input  req_busy, gnt, err_drop, tft_dc, tft_data, tft_transmit
   );
endinterface

// File: rtl/tft_bus_arbiter.sv
// Burst arbiter sharing one TFT byte transmitter among NUM_REQ requesters (round robin).
// Define TFT_ARB_INIT_PRIO_EN for fixed lowest-index-wins priority instead.
module tft_bus_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = 2
) (
   input  logic               clk,
   input  logic               rst,
   tft_bus_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic                 tft_dc_q, tft_dc_d;
   logic [7:0]           tft_data_q, tft_data_d;
   logic                 tft_transmit_q, tft_transmit_d;
   logic                 err_drop_q, err_drop_d;

   logic [NUM_REQ-1:0]   req_busy;
   logic                 line_free;
   logic                 accept;
   logic [IDX_W-1:0]     pick;
   logic                 pick_vld;
   int                   scan_idx;

   // The transmit term covers the cycle before the transmitter raises tft_busy.
   assign line_free = ~bus.tft_busy & ~tft_transmit_q;
   assign req_busy  = ~gnt_q | {NUM_REQ{~line_free | (state_q == DRAIN)}};
   assign accept    = (state_q == GRANT) & bus.req_tx[owner_q] & line_free;

   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      scan_idx = 0;
`ifdef TFT_ARB_INIT_PRIO_EN
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req[i]) begin
            pick     = IDX_W'(i);
            pick_vld = 1'b1;
         end
      end
`else
      // Descending scan so the requester nearest after last is the final (winning) hit.
      for (int k = NUM_REQ; k >= 1; k--) begin
         scan_idx = (int'(last_q) + k) % NUM_REQ;
         if (bus.req[scan_idx]) begin
            pick     = IDX_W'(scan_idx);
            pick_vld = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      state_d        = state_q;
      gnt_d          = gnt_q;
      owner_d        = owner_q;
      last_d         = last_q;
      tft_dc_d       = tft_dc_q;
      tft_data_d     = tft_data_q;
      tft_transmit_d = accept;
      err_drop_d     = |(bus.req_tx & req_busy);

      if (accept) begin
         tft_dc_d   = bus.req_dc[owner_q];
         tft_data_d = bus.req_data[8*owner_q +: 8];
      end

      case (state_q)
         IDLE: begin
            if (pick_vld) begin
               gnt_d       = '0;
               gnt_d[pick] = 1'b1;
               owner_d     = pick;
               state_d     = GRANT;
            end
         end
         GRANT: begin
            // A strobe accepted as req drops still needs its byte drained.
            if (!bus.req[owner_q]) begin
               if (line_free && !accept) begin
                  gnt_d   = '0;
                  last_d  = owner_q;
                  state_d = IDLE;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (line_free) begin
               gnt_d   = '0;
               last_d  = owner_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         gnt_q          <= '0;
         owner_q        <= '0;
         last_q         <= IDX_W'(NUM_REQ - 1);
         tft_dc_q       <= 1'b0;
         tft_data_q     <= 8'h00;
         tft_transmit_q <= 1'b0;
         err_drop_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         gnt_q          <= gnt_d;
         owner_q        <= owner_d;
         last_q         <= last_d;
         tft_dc_q       <= tft_dc_d;
         tft_data_q     <= tft_data_d;
         tft_transmit_q <= tft_transmit_d;
         err_drop_q     <= err_drop_d;
      end
   end

   assign bus.req_busy     = req_busy;
   assign bus.gnt          = gnt_q;
   assign bus.err_drop     = err_drop_q;
   assign bus.tft_dc       = tft_dc_q;
   assign bus.tft_data     = tft_data_q;
   assign bus.tft_transmit = tft_transmit_q;

endmodule

// File: tb/tb_tft_bus_arbiter.sv
// Scoreboard bench for tft_bus_arbiter with a simple byte-transmitter model
// that holds tft_busy for BUSY_CYC cycles after each tft_transmit pulse.
module tb_tft_bus_arbiter;

   localparam int NUM_REQ  = 3;
   localparam int BUSY_CYC = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tft_bus_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   tft_bus_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // Transmitter model; it ignores rst so an in-flight byte keeps tft_busy high.
   int busy_cnt = 0;
   assign bus.tft_busy = (busy_cnt != 0);
   always @(posedge clk) begin
      if (bus.tft_transmit)   busy_cnt <= BUSY_CYC;
      else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
   end

   // Scoreboard: strobes push {dc,data}; every observed transmit pops and compares.
   logic [8:0] exp_q[$];
   logic [8:0] mon_exp;
   int         tx_cnt   = 0;
   int         drop_cnt = 0;
   always @(negedge clk) begin
      if (bus.err_drop) drop_cnt++;
      if (bus.tft_transmit) begin
         tx_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL tx_unexpected got dc=%0b data=%02h want no transmit",
                     bus.tft_dc, bus.tft_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if ({bus.tft_dc, bus.tft_data} !== mon_exp) begin
               bad++;
               $display("[TB] FAIL tx_byte got dc=%0b data=%02h want dc=%0b data=%02h",
                        bus.tft_dc, bus.tft_data, mon_exp[8], mon_exp[7:0]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input int i, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (bus.req_busy[i] == 1'b0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic strobe(input int i, input bit dc, input logic [7:0] d, output bit ok);
      wait_ready(i, ok);
      if (ok) begin
         bus.req_tx[i]          = 1'b1;
         bus.req_dc[i]          = dc;
         bus.req_data[8*i +: 8] = d;
         exp_q.push_back({dc, d});
         tick();
         bus.req_tx[i] = 1'b0;
      end
   endtask

   task automatic wait_gnt(input bit want_zero, output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (want_zero ? (bus.gnt == '0) : (bus.gnt != '0)) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.req      = '0;
      bus.req_tx   = '0;
      bus.req_dc   = '0;
      bus.req_data = '0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      total++;
      if (bus.gnt !== 3'b000) begin
         bad++; $display("[TB] FAIL reset_gnt got=%b want=000", bus.gnt);
      end
      total++;
      if (bus.tft_transmit !== 1'b0 || bus.tft_dc !== 1'b0 || bus.tft_data !== 8'h00) begin
         bad++;
         $display("[TB] FAIL reset_tft got tx=%b dc=%b data=%02h want 0/0/00",
                  bus.tft_transmit, bus.tft_dc, bus.tft_data);
      end
      total++;
      if (bus.err_drop !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_err got=%b want=0", bus.err_drop);
      end
      total++;
      if (bus.req_busy !== 3'b111) begin
         bad++; $display("[TB] FAIL reset_req_busy got=%b want=111", bus.req_busy);
      end
   endtask

   task automatic test_single_burst();
      bit         ok;
      int         tx0;
      bit         dcs[4]   = '{1'b0, 1'b1, 1'b1, 1'b1};
      logic [7:0] datas[4] = '{8'h2A, 8'h00, 8'h00, 8'hEF};
      tx0     = tx_cnt;
      bus.req = 3'b001;
      tick();
      total++;
      if (bus.gnt !== 3'b001) begin
         bad++; $display("[TB] FAIL burst_gnt_latency got=%b want=001", bus.gnt);
      end
      for (int b = 0; b < 4; b++) begin
         strobe(0, dcs[b], datas[b], ok);
         total++;
         if (!ok || bus.tft_transmit !== 1'b1) begin
            bad++;
            $display("[TB] FAIL burst_accept_%0d got ready=%0b tx=%b want ready=1 tx=1",
                     b, ok, bus.tft_transmit);
         end
      end
      bus.req = 3'b000;
      wait_gnt(1'b1, ok);
      total++;
      if (!ok || bus.tft_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL burst_release got released=%0b busy=%b want released=1 busy=0",
                  ok, bus.tft_busy);
      end
      total++;
      if (tx_cnt - tx0 != 4 || exp_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL burst_count got tx=%0d pending=%0d want tx=4 pending=0",
                  tx_cnt - tx0, exp_q.size());
      end
   endtask

   task automatic test_round_robin();
      bit               ok;
      int               owner;
      logic [2:0]       mask;
      logic [2:0]       want[3];
`ifdef TFT_ARB_INIT_PRIO_EN
      mask = 3'b111;
      want = '{3'b001, 3'b001, 3'b001};
`else
      mask = 3'b110;
      want = '{3'b010, 3'b100, 3'b010};
`endif
      bus.req = mask;
      for (int k = 0; k < 3; k++) begin
         wait_gnt(1'b0, ok);
         total++;
         if (!ok || bus.gnt !== want[k]) begin
            bad++;
            $display("[TB] FAIL rr_grant_%0d got=%b want=%b", k, bus.gnt, want[k]);
         end
         owner = 0;
         for (int i = 0; i < NUM_REQ; i++) if (bus.gnt[i]) owner = i;
         strobe(owner, 1'b1, 8'h10 + 8'(k), ok);
         total++;
         if (!ok) begin
            bad++; $display("[TB] FAIL rr_strobe_%0d got ready=0 want ready=1", k);
         end
         bus.req[owner] = 1'b0;
         wait_gnt(1'b1, ok);
         total++;
         if (!ok) begin
            bad++; $display("[TB] FAIL rr_release_%0d got gnt=%b want=000", k, bus.gnt);
         end
         if (k < 2) bus.req[owner] = 1'b1;
         else       bus.req = '0;
      end
   endtask

   task automatic test_drop_with_strobe();
      bit ok;
      int held;
      bus.req = 3'b010;
      wait_gnt(1'b0, ok);
      total++;
      if (!ok || bus.gnt !== 3'b010) begin
         bad++; $display("[TB] FAIL drop_grant got=%b want=010", bus.gnt);
      end
      wait_ready(1, ok);
      bus.req_tx[1]      = 1'b1;
      bus.req_dc[1]      = 1'b1;
      bus.req_data[15:8] = 8'h5A;
      bus.req[1]         = 1'b0;
      exp_q.push_back({1'b1, 8'h5A});
      tick();
      bus.req_tx[1] = 1'b0;
      total++;
      if (!ok || bus.tft_transmit !== 1'b1 || bus.gnt !== 3'b010 || bus.req_busy[1] !== 1'b1) begin
         bad++;
         $display("[TB] FAIL drop_accept got tx=%b gnt=%b busy1=%b want tx=1 gnt=010 busy1=1",
                  bus.tft_transmit, bus.gnt, bus.req_busy[1]);
      end
      held = 0;
      ok   = 1'b0;
      for (int n = 0; n < 40; n++) begin
         if (bus.gnt == '0) begin
            ok = 1'b1;
            break;
         end
         held++;
         tick();
      end
      total++;
      if (!ok || bus.tft_busy !== 1'b0) begin
         bad++;
         $display("[TB] FAIL drop_release got released=%0b busy=%b want released=1 busy=0",
                  ok, bus.tft_busy);
      end
      total++;
      if (held != BUSY_CYC + 2) begin
         bad++; $display("[TB] FAIL drop_hold got=%0d want=%0d", held, BUSY_CYC + 2);
      end
   endtask

   task automatic test_discard();
      bit ok;
      int d0;
      int tx0;
      bus.req = 3'b001;
      wait_gnt(1'b0, ok);
      total++;
      if (!ok || bus.gnt !== 3'b001) begin
         bad++; $display("[TB] FAIL disc_grant got=%b want=001", bus.gnt);
      end
      strobe(0, 1'b1, 8'h11, ok);
      tick();
      total++;
      if (!ok || bus.tft_busy !== 1'b1) begin
         bad++; $display("[TB] FAIL disc_setup got busy=%b want=1", bus.tft_busy);
      end
      d0  = drop_cnt;
      tx0 = tx_cnt;
      bus.req_tx[0]     = 1'b1;
      bus.req_dc[0]     = 1'b0;
      bus.req_data[7:0] = 8'h77;
      tick();
      bus.req_tx[0] = 1'b0;
      total++;
      if (bus.err_drop !== 1'b1 || bus.tft_transmit !== 1'b0 || bus.tft_data !== 8'h11) begin
         bad++;
         $display("[TB] FAIL disc_owner_busy got err=%b tx=%b data=%02h want 1/0/11",
                  bus.err_drop, bus.tft_transmit, bus.tft_data);
      end
      bus.req_tx[2]       = 1'b1;
      bus.req_data[23:16] = 8'h99;
      tick();
      bus.req_tx[2] = 1'b0;
      total++;
      if (bus.err_drop !== 1'b1 || bus.tft_transmit !== 1'b0) begin
         bad++;
         $display("[TB] FAIL disc_not_owner got err=%b tx=%b want 1/0",
                  bus.err_drop, bus.tft_transmit);
      end
      tick();
      total++;
      if (bus.err_drop !== 1'b0 || drop_cnt - d0 != 2 || tx_cnt != tx0 || bus.tft_data !== 8'h11) begin
         bad++;
         $display("[TB] FAIL disc_totals got err=%b drops=%0d tx=%0d data=%02h want 0/2/0/11",
                  bus.err_drop, drop_cnt - d0, tx_cnt - tx0, bus.tft_data);
      end
      bus.req = 3'b000;
      wait_gnt(1'b1, ok);
      total++;
      if (!ok) begin
         bad++; $display("[TB] FAIL disc_release got gnt=%b want=000", bus.gnt);
      end
   endtask

   task automatic test_reset_mid_burst();
      bit ok;
      bus.req = 3'b001;
      wait_gnt(1'b0, ok);
      strobe(0, 1'b0, 8'h2C, ok);
      total++;
      if (!ok || bus.tft_transmit !== 1'b1 || bus.gnt !== 3'b001) begin
         bad++;
         $display("[TB] FAIL rst_setup got tx=%b gnt=%b want tx=1 gnt=001",
                  bus.tft_transmit, bus.gnt);
      end
      rst     = 1'b1;
      bus.req = 3'b000;
      tick();
      total++;
      if (bus.gnt !== 3'b000 || bus.tft_transmit !== 1'b0 || bus.tft_data !== 8'h00 ||
          bus.req_busy !== 3'b111) begin
         bad++;
         $display("[TB] FAIL rst_mid got gnt=%b tx=%b data=%02h busy=%b want 000/0/00/111",
                  bus.gnt, bus.tft_transmit, bus.tft_data, bus.req_busy);
      end
      rst = 1'b0;
      for (int n = 0; n < 20 && bus.tft_busy; n++) tick();
      bus.req = 3'b101;
      tick();
      total++;
      if (bus.gnt !== 3'b001) begin
         bad++; $display("[TB] FAIL rst_last_scan got=%b want=001", bus.gnt);
      end
      bus.req = 3'b000;
      wait_gnt(1'b1, ok);
      bus.req = 3'b100;
      tick();
      total++;
      if (!ok || bus.gnt !== 3'b100) begin
         bad++; $display("[TB] FAIL rst_req2 got=%b want=100", bus.gnt);
      end
      bus.req = 3'b000;
      wait_gnt(1'b1, ok);
      total++;
      if (!ok || exp_q.size() != 0) begin
         bad++;
         $display("[TB] FAIL final_drain got released=%0b pending=%0d want 1/0", ok, exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      $display("[TB] starting tft_bus_arbiter bench");
      test_reset();
      test_single_burst();
      test_round_robin();
      test_drop_with_strobe();
      test_discard();
      test_reset_mid_burst();
      tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
